// File: rtl/check_node_message_generator.sv
// Check-node output stage: turns a row's min/second_min/pos/signs into DEG
// sign-magnitude check-to-variable messages. Define OFFSET_MIN_SUM_EN for offset min-sum.
module check_node_message_generator #(
  parameter int DEG    = 40,
  parameter int W      = 32,
  parameter int IDXW   = 6,
  parameter int OFFSET = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [W-1:0]    min,
  input  logic [W-1:0]    second_min,
  input  logic [IDXW-1:0] pos,
  input  logic [DEG-1:0]  signs,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_index,
  output logic [W-1:0]    out_msg,
  output logic            done
);

  localparam logic [1:0]      ST_IDLE  = 2'd0;
  localparam logic [1:0]      ST_EMIT  = 2'd1;
  localparam logic [1:0]      ST_DONE  = 2'd2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEG - 1);
  localparam logic [W-1:0]    MAG_MAX  = {1'b0, {(W-1){1'b1}}};

  function automatic logic parity_f(input logic [DEG-1:0] v);
    return ^v;
  endfunction

  function automatic logic [W-2:0] clamp_f(input logic [W-1:0] m);
    if (m[W-1]) begin
      return MAG_MAX[W-2:0];
    end else begin
      return m[W-2:0];
    end
  endfunction

  logic [1:0]      state_r;
  logic [W-1:0]    min_r;
  logic [W-1:0]    second_min_r;
  logic [IDXW-1:0] pos_r;
  logic [DEG-1:0]  signs_r;
  logic            parity_r;
  logic [IDXW-1:0] idx_r;
  logic            busy_r;
  logic            out_valid_r;
  logic [IDXW-1:0] out_index_r;
  logic [W-1:0]    out_msg_r;
  logic            done_r;

  logic [IDXW-1:0] sel_idx_s;
  logic [W-1:0]    mag_sel_s;
  logic [W-1:0]    mag_s;
  logic            sign_s;
  logic [W-1:0]    msg_s;

  // Message for the edge that will be presented next; the first edge is loaded
  // one cycle after capture so the output path only ever sees registered state.
  always_comb begin
    sel_idx_s = idx_r;
    mag_sel_s = min_r;
    mag_s     = min_r;
    sign_s    = parity_r;
    if (out_valid_r) begin
      sel_idx_s = idx_r + IDXW'(1);
    end else begin
      sel_idx_s = idx_r;
    end
    if (sel_idx_s == pos_r) begin
      mag_sel_s = second_min_r;
    end else begin
      mag_sel_s = min_r;
    end
`ifdef OFFSET_MIN_SUM_EN
    if (mag_sel_s > W'(OFFSET)) begin
      mag_s = mag_sel_s - W'(OFFSET);
    end else begin
      mag_s = {W{1'b0}};
    end
`else
    mag_s = mag_sel_s;
`endif
    // parity ^ own sign leaves the XOR of every other edge's sign
    if (int'(sel_idx_s) < DEG) begin
      sign_s = parity_r ^ signs_r[sel_idx_s];
    end else begin
      sign_s = parity_r;
    end
    msg_s = {sign_s, clamp_f(mag_s)};
  end

  // Row capture, stream sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      min_r        <= {W{1'b0}};
      second_min_r <= {W{1'b0}};
      pos_r        <= {IDXW{1'b0}};
      signs_r      <= {DEG{1'b0}};
      parity_r     <= 1'b0;
      idx_r        <= {IDXW{1'b0}};
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      out_index_r  <= {IDXW{1'b0}};
      out_msg_r    <= {W{1'b0}};
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            min_r        <= min;
            second_min_r <= second_min;
            pos_r        <= pos;
            signs_r      <= signs;
            parity_r     <= parity_f(signs);
            idx_r        <= {IDXW{1'b0}};
            busy_r       <= 1'b1;
            state_r      <= ST_EMIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_index_r <= sel_idx_s;
            out_msg_r   <= msg_s;
          end else if (out_ready) begin
            if (idx_r == LAST_IDX) begin
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              idx_r       <= sel_idx_s;
              out_index_r <= sel_idx_s;
              out_msg_r   <= msg_s;
            end
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_index = out_index_r;
  assign out_msg   = out_msg_r;
  assign done      = done_r;

endmodule

// File: tb/tb_check_node_message_generator.sv
// Scoreboard bench for check_node_message_generator: randomized rows against a
// per-edge reference model; a negedge monitor pops and compares accepted messages.
module tb_check_node_message_generator;

  localparam int DEG    = 40;
  localparam int W      = 32;
  localparam int IDXW   = 6;
  localparam int OFFSET = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [W-1:0]    min = '0;
  logic [W-1:0]    second_min = '0;
  logic [IDXW-1:0] pos = '0;
  logic [DEG-1:0]  signs = '0;
  logic            busy;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [IDXW-1:0] out_index;
  logic [W-1:0]    out_msg;
  logic            done;

  check_node_message_generator #(.DEG(DEG), .W(W), .IDXW(IDXW), .OFFSET(OFFSET)) dut (
    .clk(clk), .reset(reset), .start(start), .min(min), .second_min(second_min),
    .pos(pos), .signs(signs), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_msg(out_msg), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [W-1:0]    msg;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: magnitude by position, sign = parity of negative OTHER edges
  function automatic logic [W-1:0] ref_msg(input int i, input logic [W-1:0] mn,
                                           input logic [W-1:0] sm, input int p,
                                           input logic [DEG-1:0] sg);
    longint mag;
    int     neg_others;
    logic [W-1:0] r;
    neg_others = 0;
    mag = (i == p) ? longint'(sm) : longint'(mn);
`ifdef OFFSET_MIN_SUM_EN
    mag = (mag > OFFSET) ? mag - OFFSET : 0;
`endif
    if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
    for (int j = 0; j < DEG; j++) begin
      if (j != i && sg[j]) neg_others++;
    end
    r = W'(mag);
    r[W-1] = neg_others[0];
    return r;
  endfunction

  logic            pv_hold = 1'b0;
  logic [IDXW-1:0] p_idx;
  logic [W-1:0]    p_msg;

  // Monitor: hold-under-backpressure, scoreboard pop on accept, done checks
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      pv_hold = 1'b0;
    end else begin
      if (pv_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_index", out_index, p_idx);
        chk("hold_msg", out_msg, p_msg);
      end
      pv_hold = out_valid && !out_ready;
      p_idx = out_index;
      p_msg = out_msg;
      if (out_valid) begin
        chk("busy_in_emit", busy, 1);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_msg: got index %0d msg %0h expected none", out_index, out_msg);
          end else begin
            e = exp_q.pop_front();
            chk("index", out_index, e.idx);
            chk("msg", out_msg, e.msg);
            if (exp_q.size() == 0) last_acc_cyc = cyc;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_queue_empty", exp_q.size(), 0);
        chk("done_cycle", cyc, last_acc_cyc + 1);
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [W-1:0] mn, input logic [W-1:0] sm,
                          input logic [IDXW-1:0] p, input logic [DEG-1:0] sg);
    exp_t e;
    for (int i = 0; i < DEG; i++) begin
      e.idx = IDXW'(i);
      e.msg = ref_msg(i, mn, sm, int'(p), sg);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_start(input logic [W-1:0] mn, input logic [W-1:0] sm,
                             input logic [IDXW-1:0] p, input logic [DEG-1:0] sg);
    push_row(mn, sm, p, sg);
    min = mn; second_min = sm; pos = p; signs = sg;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    min = $urandom; second_min = $urandom; pos = IDXW'($urandom); signs = {$urandom, $urandom};
  endtask

  // mode 0: ready always; 1: random ready; 2: 3-cycle stall at index 10; 3: start pulse mid-stream
  task automatic run_row(input logic [W-1:0] mn, input logic [W-1:0] sm,
                         input logic [IDXW-1:0] p, input logic [DEG-1:0] sg, input int mode);
    int start_cyc, d0, stall, budget;
    issue_start(mn, sm, p, sg);
    start_cyc = cyc;
    d0 = done_cnt;
    chk("busy_after_start", busy, 1);
    chk("no_valid_yet", out_valid, 0);
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_index", out_index, 0);
    stall = 0;
    budget = 0;
    while (done_cnt == d0 && budget < 400) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && out_index == IDXW'(10) && stall < 3) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        3: begin
          out_ready = 1'b1;
          start = (out_valid && out_index == IDXW'(15));
          if (start) begin
            min = $urandom; second_min = $urandom; pos = '0; signs = {DEG{1'b1}};
          end
        end
        default: out_ready = 1'b1;
      endcase
      tick();
      budget++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("row_done", done_cnt, d0 + 1);
    if (mode == 0) chk("stream_cycles", done_cyc - start_cyc, DEG + 1);
    if (mode == 2) chk("stall_cycles", stall, 3);
  endtask

  task automatic reset_mid_stream();
    int budget, dd;
    issue_start(32'd11, 32'd22, 6'd5, {$urandom, $urandom});
    budget = 0;
    while (!(out_valid && out_index == IDXW'(20)) && budget < 200) begin
      tick();
      budget++;
    end
    chk("reached_index20", out_index, 20);
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_index", out_index, 0);
    chk("rst_msg", out_msg, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    exp_q.delete();
    dd = done_cnt;
    repeat (4) tick();
    chk("no_done_after_reset", done_cnt, dd);
    out_ready = 1'b1;
  endtask

  initial begin
    logic [W-1:0] mn, sm;
    repeat (2) tick();
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_index", out_index, 0);
    chk("reset_msg", out_msg, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    tick();
    chk("idle_no_busy", busy, 0);

    run_row(32'd5, 32'd9, 6'd3, {DEG{1'b0}}, 0);
    run_row(32'd5, 32'd9, 6'd3, DEG'(64'd1 << 7), 0);
    run_row($urandom_range(0, 1000), $urandom_range(0, 1000), 6'd12, {$urandom, $urandom}, 2);
    run_row(32'h8000_0004, 32'hFFFF_FFFF, 6'd3, {$urandom, $urandom}, 1);
    run_row(32'd7, 32'd2, 6'd45, {$urandom, $urandom}, 0);
    run_row(32'd3, 32'd3, 6'd39, {$urandom, $urandom}, 3);
    reset_mid_stream();
    run_row(32'd13, 32'd17, 6'd0, {$urandom, $urandom}, 0);
    run_row(32'd0, 32'd0, 6'd20, {DEG{1'b1}}, 1);
`ifdef OFFSET_MIN_SUM_EN
    run_row(32'd1, 32'd9, 6'd0, {DEG{1'b0}}, 0);
`endif
    for (int r = 0; r < 6; r++) begin
      mn = (r % 2 == 0) ? W'($urandom_range(0, 5000)) : W'($urandom);
      sm = mn + W'($urandom_range(0, 100));
      run_row(mn, sm, IDXW'($urandom_range(0, 63)), {$urandom, $urandom}, 1);
    end
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
